alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Issue stage feeding the EX-stage ALU: decodes the 2-bit main-control ALUOp and the 6-bit R-type funct field into the ALU's 4-bit OpSel. It registers the decoded operation with both 32-bit operands and the destination register, and presents them to EX through a valid/ready handshake. A two-entry skid buffer lets EX back-pressure without combinational ready paths. Flush inserts bubbles on branch mispredict.

## Interface
Parameters:
- DATA_W, 32, operand width
- REG_W, 5, destination register index width

Ports:
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ID has an instruction
- in_ready  out  1  stage can accept; equals NOT skid-entry-valid (registered source)
- in_aluop  in  2  main-control ALUOp
- in_funct  in  6  instruction[5:0]
- in_a, in_b  in  DATA_W  operands
- in_rd  in  REG_W  destination register
- flush  in  1  discard all held and incoming entries
- out_valid  out  1  EX payload valid
- out_ready  in  1  EX accepts
- out_opsel  out  4  OpSel to ALU
- out_a, out_b  out  DATA_W  registered operands
- out_rd  out  REG_W  registered destination
- out_illegal  out  1  (macro only) entry carries an unsupported funct

## Operation
- Decode (combinational on input, result stored):
  - ALUOp 00 -> 4'h2 (add, lw/sw)
  - ALUOp 01 -> 4'h6 (sub, beq)
  - ALUOp 11 -> 4'h7 (slt, slti)
  - ALUOp 10 -> by funct: 100000 -> 4'h2; 100010 -> 4'h6; 100100 -> 4'h0; 100101 -> 4'h1; 101010 -> 4'h7; any other -> 4'hF (ALU yields 0)
- Storage: main entry (drives outputs) and skid entry.
- States: EMPTY (no entry valid), ONE (main valid), TWO (main and skid valid).
- Accept when in_valid && in_ready. Consume when out_valid && out_ready.
- EMPTY: accept -> ONE.
- ONE:
  - accept and consume -> ONE (main reloaded)
  - consume only -> EMPTY
  - accept only -> TWO (input goes to skid)
- TWO: in_ready=0. Consume -> skid moves to main -> ONE.
- Order is strictly FIFO. No entry is duplicated or dropped except by flush.
- flush has priority over everything: next state EMPTY. An input presented in the flush cycle is dropped even if accepted. A consume in the flush cycle still completes for EX.

## Timing
- Latency: input accepted at edge N appears on outputs after edge N; out_valid high in cycle N+1 when EMPTY.
- Throughput: one per cycle while out_ready stays high.
- in_ready depends only on registers; no combinational path from out_ready to in_ready.
- Outputs are registered; payload is held stable while out_valid && !out_ready.
- Reset values: state EMPTY; out_valid 0; out_opsel 4'h0; out_a, out_b 0; out_rd 0; out_illegal 0; in_ready 1 in the first cycle after reset.
- rst asserted mid-operation discards both entries at the next edge, identical to flush.

## Configuration
- ALU_ISSUE_ILLEGAL_TRAP_EN defined:
  - Unsupported funct under ALUOp 10 sets a per-entry illegal bit, output on out_illegal.
  - OpSel is still 4'hF.
  - The entry passes normally; EX raises the exception.
- Not defined:
  - out_illegal port absent; no illegal bit stored.
  - Unsupported funct yields OpSel 4'hF silently.

## Structure
- Shared package alu_pkg:
  - OpSel localparams: OP_AND=4'h0, OP_OR=4'h1, OP_ADD=4'h2, OP_SUB=4'h6, OP_SLT=4'h7, OP_NOP=4'hF
  - ALUOp encodings and funct codes
  - payload struct {opsel, a, b, rd, illegal}
- One sub-module, alu_op_decode: a purely combinational ALUOp/funct -> OpSel (+illegal) decoder, reusable by the ALU testbench.
- The skid buffer and state logic stay in alu_issue_stage.

## Test plan
- Decode sweep: ALUOp 10, funct 100100 / 100101 / 100000 / 100010 / 101010 -> out_opsel 0 / 1 / 2 / 6 / 7, one cycle after accept. ALUOp 00 / 01 / 11 -> 2 / 6 / 7.
- Back-pressure: stream in_a = 1..6 with out_ready low from the 2nd accept. Required: in_ready drops after two accepts, out_a holds 1, and releasing out_ready yields 1..6 in order with no loss.
- Full throughput: out_ready=1, in_valid=1 for 10 cycles -> 10 consecutive out_valid cycles, in_ready never low.
- Flush in TWO with in_valid high -> out_valid=0 next cycle and in_ready=1; the flushed inputs never appear.
- Reset mid-stream with two entries held -> all outputs 0 and in_ready=1 the next cycle.
- Macro on: ALUOp 10, funct 000000 -> out_opsel 4'hF, out_illegal=1. Macro off: same stimulus -> 4'hF, no out_illegal port.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings and the issue-stage payload type.
// The payload carries an illegal bit only when ALU_ISSUE_ILLEGAL_TRAP_EN is defined.
package alu_pkg;

  localparam int unsigned PAYLOAD_DATA_W = 32;
  localparam int unsigned PAYLOAD_REG_W  = 5;
  localparam int unsigned OPSEL_W        = 4;
  localparam int unsigned FUNCT_W        = 6;

  localparam logic [OPSEL_W-1:0] OP_AND = 4'h0;
  localparam logic [OPSEL_W-1:0] OP_OR  = 4'h1;
  localparam logic [OPSEL_W-1:0] OP_ADD = 4'h2;
  localparam logic [OPSEL_W-1:0] OP_SUB = 4'h6;
  localparam logic [OPSEL_W-1:0] OP_SLT = 4'h7;
  localparam logic [OPSEL_W-1:0] OP_NOP = 4'hF;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_SLT   = 2'b11
  } aluop_e;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

  typedef struct packed {
    logic [OPSEL_W-1:0]        opsel;
    logic [PAYLOAD_DATA_W-1:0] a;
    logic [PAYLOAD_DATA_W-1:0] b;
    logic [PAYLOAD_REG_W-1:0]  rd;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    logic                      illegal;
`endif
  } issue_payload_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct to OpSel decoder; o_illegal exists only with
// ALU_ISSUE_ILLEGAL_TRAP_EN defined.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0]         i_aluop,
  input  logic [FUNCT_W-1:0] i_funct,
  output logic [OPSEL_W-1:0] o_opsel
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  ,
  output logic               o_illegal
`endif
);

  always_comb begin
    o_opsel = OP_NOP;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    o_illegal = 1'b0;
`endif
    case (aluop_e'(i_aluop))
      ALUOP_ADD: o_opsel = OP_ADD;
      ALUOP_SUB: o_opsel = OP_SUB;
      ALUOP_SLT: o_opsel = OP_SLT;
      ALUOP_RTYPE: begin
        case (i_funct)
          FUNCT_ADD: o_opsel = OP_ADD;
          FUNCT_SUB: o_opsel = OP_SUB;
          FUNCT_AND: o_opsel = OP_AND;
          FUNCT_OR:  o_opsel = OP_OR;
          FUNCT_SLT: o_opsel = OP_SLT;
          default: begin
            // Unsupported funct: ALU sees a NOP select and yields 0
            o_opsel = OP_NOP;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
            o_illegal = 1'b1;
`endif
          end
        endcase
      end
      default: o_opsel = OP_NOP;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode into a main/skid two-entry buffer with registered
// valid/ready. ALU_ISSUE_ILLEGAL_TRAP_EN adds the out_illegal port.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = PAYLOAD_DATA_W,
  parameter int unsigned REG_W  = PAYLOAD_REG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_aluop,
  input  logic [FUNCT_W-1:0] in_funct,
  input  logic [DATA_W-1:0]  in_a,
  input  logic [DATA_W-1:0]  in_b,
  input  logic [REG_W-1:0]   in_rd,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPSEL_W-1:0] out_opsel,
  output logic [DATA_W-1:0]  out_a,
  output logic [DATA_W-1:0]  out_b,
  output logic [REG_W-1:0]   out_rd
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  ,
  output logic               out_illegal
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e         r_state, w_state_nxt;
  issue_payload_t r_main, r_skid, w_main_nxt, w_skid_nxt, w_dec;
  logic           r_out_valid, r_in_ready;
  logic           w_out_valid_nxt, w_in_ready_nxt;
  logic           w_accept, w_consume;
  logic [OPSEL_W-1:0] w_opsel;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  logic           w_illegal;
`endif

  alu_op_decode u_decode (
    .i_aluop  (in_aluop),
    .i_funct  (in_funct),
    .o_opsel  (w_opsel)
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    ,
    .o_illegal(w_illegal)
`endif
  );

  // Payload built from the incoming instruction
  always_comb begin
    w_dec       = '0;
    w_dec.opsel = w_opsel;
    w_dec.a     = PAYLOAD_DATA_W'(in_a);
    w_dec.b     = PAYLOAD_DATA_W'(in_b);
    w_dec.rd    = PAYLOAD_REG_W'(in_rd);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    w_dec.illegal = w_illegal;
`endif
  end

  assign w_accept  = in_valid && r_in_ready;
  assign w_consume = r_out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_main      <= w_main_nxt;
      r_skid      <= w_skid_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_in_ready  <= w_in_ready_nxt;
    end
  end

  // Next state; valid/ready are registered copies of the next occupancy
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_main_nxt  = w_dec;
          w_state_nxt = S_ONE;
        end
      end
      S_ONE: begin
        if (w_accept && w_consume) begin
          w_main_nxt = w_dec;
        end else if (w_consume) begin
          w_state_nxt = S_EMPTY;
        end else if (w_accept) begin
          w_skid_nxt  = w_dec;
          w_state_nxt = S_TWO;
        end
      end
      S_TWO: begin
        if (w_consume) begin
          w_main_nxt  = r_skid;
          w_state_nxt = S_ONE;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    // Flush drops everything, including an input accepted this cycle
    if (flush) begin
      w_state_nxt = S_EMPTY;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
    end
    w_out_valid_nxt = (w_state_nxt != S_EMPTY);
    w_in_ready_nxt  = (w_state_nxt != S_TWO);
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_opsel = r_main.opsel;
  assign out_a     = DATA_W'(r_main.a);
  assign out_b     = DATA_W'(r_main.b);
  assign out_rd    = REG_W'(r_main.rd);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  assign out_illegal = r_main.illegal;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: a two-deep FIFO reference with
// decode rules; checks valid/ready every cycle and payload whenever valid.
module tb_alu_issue_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [1:0]    in_aluop;
  logic [5:0]    in_funct;
  logic [DW-1:0] in_a, in_b, out_a, out_b;
  logic [RW-1:0] in_rd, out_rd;
  logic [3:0]    out_opsel;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  logic          out_illegal;
`endif

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_W(DW), .REG_W(RW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_aluop (in_aluop),
    .in_funct (in_funct),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_rd    (in_rd),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_opsel(out_opsel),
    .out_a    (out_a),
    .out_b    (out_b),
    .out_rd   (out_rd)
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    ,
    .out_illegal(out_illegal)
`endif
  );

  typedef struct {
    logic [3:0]    opsel;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [RW-1:0] rd;
    logic          illegal;
  } exp_t;

  exp_t q[$];
  exp_t stim_exp;
  bit   zero_out = 1'b0;
  bit   acc_flag = 1'b0;
  bit   mon_en   = 1'b0;
  int   n_pass   = 0;
  int   n_total  = 0;

  // Reference decode straight from the ALUOp/funct table
  function automatic exp_t ref_model(input logic [1:0] op, input logic [5:0] f,
                                     input logic [DW-1:0] a, input logic [DW-1:0] b,
                                     input logic [RW-1:0] rd);
    exp_t e;
    e.a = a; e.b = b; e.rd = rd; e.illegal = 1'b0;
    if (op == 2'b00)      e.opsel = 4'h2;
    else if (op == 2'b01) e.opsel = 4'h6;
    else if (op == 2'b11) e.opsel = 4'h7;
    else if (f == 6'h20)  e.opsel = 4'h2;
    else if (f == 6'h22)  e.opsel = 4'h6;
    else if (f == 6'h24)  e.opsel = 4'h0;
    else if (f == 6'h25)  e.opsel = 4'h1;
    else if (f == 6'h2a)  e.opsel = 4'h7;
    else begin
      e.opsel   = 4'hF;
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compare against the head of the scoreboard, then apply this edge
  always @(negedge clk) begin
    bit cons, acc;
    if (mon_en) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (q.size() > 0) begin
        chk("out_opsel", 32'(out_opsel), 32'(q[0].opsel));
        chk("out_a", out_a, q[0].a);
        chk("out_b", out_b, q[0].b);
        chk("out_rd", 32'(out_rd), 32'(q[0].rd));
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        chk("out_illegal", 32'(out_illegal), 32'(q[0].illegal));
`endif
      end else if (zero_out) begin
        chk("rst_opsel", 32'(out_opsel), 32'h0);
        chk("rst_a", out_a, 32'h0);
        chk("rst_b", out_b, 32'h0);
        chk("rst_rd", 32'(out_rd), 32'h0);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        chk("rst_illegal", 32'(out_illegal), 32'h0);
`endif
      end
      cons = (q.size() > 0) && out_ready;
      acc  = in_valid && (q.size() < 2);
      acc_flag = acc && !rst && !flush;
      if (rst || flush) begin
        q.delete();
        if (rst) zero_out = 1'b1;
      end else begin
        if (cons) void'(q.pop_front());
        if (acc) begin
          q.push_back(stim_exp);
          zero_out = 1'b0;
        end
      end
    end
  end

  task automatic cyc(input bit v, input logic [1:0] op, input logic [5:0] f,
                     input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [RW-1:0] rd,
                     input bit ordy, input bit fl, input bit r);
    in_valid  = v;
    in_aluop  = op;
    in_funct  = f;
    in_a      = a;
    in_b      = b;
    in_rd     = rd;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    stim_exp  = ref_model(op, f, a, b, rd);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 6'h0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] sw_op [9];
    logic [5:0] sw_fn [9];
    int idx;
    sw_op = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10};
    sw_fn = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2a, 6'h3f, 6'h24, 6'h00, 6'h00};

    in_valid = 1'b0; in_aluop = '0; in_funct = '0; in_a = '0; in_b = '0; in_rd = '0;
    out_ready = 1'b0; flush = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    zero_out = 1'b1;
    mon_en   = 1'b1;
    cyc(1'b1, 2'b00, 6'h0, 32'h5, 32'h6, 5'd3, 1'b1, 1'b0, 1'b1);
    idle(1);

    // Decode sweep, including the unsupported funct under ALUOp 10
    for (int i = 0; i < 9; i++)
      cyc(1'b1, sw_op[i], sw_fn[i], $urandom, $urandom, 5'($urandom), 1'b1, 1'b0, 1'b0);
    idle(2);

    // Back-pressure: stream 1..6 with EX stalled, then release
    idx = 1;
    for (int c = 0; c < 40 && idx <= 6; c++) begin
      cyc(1'b1, 2'b00, 6'h0, 32'(idx), ~32'(idx), 5'(idx), c >= 5, 1'b0, 1'b0);
      if (acc_flag) idx++;
    end
    chk("bp_all_accepted", 32'(idx), 32'd7);
    idle(3);
    chk("bp_drained", 32'(q.size()), 32'd0);

    // Full throughput
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 2'($urandom), 6'h20, $urandom, $urandom, 5'($urandom), 1'b1, 1'b0, 1'b0);
    idle(2);

    // Flush with two entries held and a new input presented
    cyc(1'b1, 2'b01, 6'h0, 32'h11, 32'h12, 5'd1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'b01, 6'h0, 32'h21, 32'h22, 5'd2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'b10, 6'h25, 32'hdead, 32'hbeef, 5'd9, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Reset mid-stream with two entries held
    cyc(1'b1, 2'b11, 6'h0, 32'h31, 32'h32, 5'd4, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'b11, 6'h0, 32'h41, 32'h42, 5'd5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 6'h0, 32'h51, 32'h52, 5'd6, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [5:0] f;
      f = ($urandom_range(0, 9) < 7) ? sw_fn[$urandom_range(0, 4)] : 6'($urandom);
      cyc($urandom_range(0, 3) != 0, 2'($urandom), f, $urandom, $urandom, 5'($urandom),
          $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0, $urandom_range(0, 79) == 0);
    end
    idle(4);
    chk("final_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
